// File: rtl/bus_exerciser.sv
// bus_exerciser -- pattern generator / capture block for a bidirectional bus.
//
// A falling edge on _CLOCK steps an LW-bit state register. While _DENA is low
// the register drives DATA/LINK and advances by MODE: LFSR, count, rotate or
// hold. While _DENA is high it captures the inverted pins into its low bits.
//
// Ports:
//   FIFTYMHZ  in    sole clock
//   _RESET    in    asynchronous active-low reset
//   _CLOCK    in    step strobe (asynchronous); a step follows each falling edge
//   _DENA     in    low: drive DATA/LINK, high: capture from DATA/LINK
//   MODE      in    00 LFSR, 01 count, 10 rotate, 11 hold/resync
//   DATA      inout DW-bit data lines
//   LINK      inout link line
//   AUX       out   state[DW+AW:DW+1]
//   LEDS      out   {state[5:0] or errcnt, synced _DENA, synced clok}
//
// Optional feature: define BUS_EXERCISER_ERRCNT_EN to add a loopback checker
// that compares each capture against an expected LFSR sequence and shows a
// saturating 6-bit error count on LEDS[7:2].
module bus_exerciser #(
    parameter int            DW   = 12,
    parameter int            LW   = 32,
    parameter int            AW   = 4,
    parameter logic [LW-1:0] SEED = 32'h87654321,
    parameter logic [LW-1:0] TAPS = 32'h80200003
) (
    input  logic          FIFTYMHZ,
    input  logic          _RESET,
    input  logic          _CLOCK,
    input  logic          _DENA,
    input  logic [1:0]    MODE,
    inout  wire  [DW-1:0] DATA,
    inout  wire           LINK,
    output logic [AW-1:0] AUX,
    output logic [7:0]    LEDS
);

    // LFSR advance; an all-zero result would lock up, so reload SEED.
    function automatic logic [LW-1:0] lfsr_next(input logic [LW-1:0] s);
        logic [LW-1:0] n;
        n = {s[LW-2:0], ^(s & TAPS)};
        return (n == '0) ? SEED : n;
    endfunction

    logic          clok_s1, clok_s2, clok_d;
    logic          dena_s1, dena_s2;
    logic [1:0]    mode_s1, mode_s2;
    logic [1:0]    vld_pipe;
    logic          armed;
    logic          step;
    logic [LW-1:0] state, state_nxt;
    logic [DW:0]   cap;

    // Bus turnaround follows the raw pin so there is no synchronizer delay.
    assign DATA = _DENA ? {DW{1'bz}} : state[DW-1:0];
    assign LINK = _DENA ? 1'bz : state[DW];
    assign AUX  = state[DW+AW:DW+1];
    assign cap  = {~LINK, ~DATA};

    always_ff @(posedge FIFTYMHZ or negedge _RESET) begin
        if (!_RESET) begin
            clok_s1  <= 1'b0;
            clok_s2  <= 1'b0;
            clok_d   <= 1'b0;
            dena_s1  <= 1'b0;
            dena_s2  <= 1'b0;
            mode_s1  <= 2'b00;
            mode_s2  <= 2'b00;
            vld_pipe <= 2'b00;
            armed    <= 1'b0;
        end else begin
            clok_s1  <= ~_CLOCK;
            clok_s2  <= clok_s1;
            clok_d   <= clok_s2;
            dena_s1  <= _DENA;
            dena_s2  <= dena_s1;
            mode_s1  <= MODE;
            mode_s2  <= mode_s1;
            vld_pipe <= {vld_pipe[0], 1'b1};
            // The synchronizer only holds real pin data once vld_pipe[1] is
            // set. Arming needs a genuine high _CLOCK seen after that, so a
            // _CLOCK held low through reset release never produces a step.
            if (vld_pipe[1] && !clok_s2)
                armed <= 1'b1;
        end
    end

    assign step = clok_s2 & ~clok_d & armed;

    always_comb begin
        state_nxt = state;
        if (step) begin
            if (dena_s2) begin
                state_nxt = {state[LW-1:DW+1], cap};
            end else begin
                case (mode_s2)
                    2'b00:   state_nxt = lfsr_next(state);
                    2'b01:   state_nxt = state + 1'b1;
                    2'b10:   state_nxt = {state[LW-2:0], state[LW-1]};
                    default: state_nxt = state;
                endcase
            end
        end
    end

    always_ff @(posedge FIFTYMHZ or negedge _RESET) begin
        if (!_RESET) state <= SEED;
        else         state <= state_nxt;
    end

`ifdef BUS_EXERCISER_ERRCNT_EN
    logic [LW-1:0] exp_q;
    logic [LW-1:0] exp_adv;
    logic [5:0]    errcnt;

    assign exp_adv = lfsr_next(exp_q);

    // Every capture advances the expected sequence; a capture in MODE 11
    // instead re-seeds it from what was captured, without comparing.
    always_ff @(posedge FIFTYMHZ or negedge _RESET) begin
        if (!_RESET) begin
            exp_q  <= SEED;
            errcnt <= 6'd0;
        end else if (step && dena_s2) begin
            if (mode_s2 == 2'b11) begin
                exp_q <= state_nxt;
            end else begin
                exp_q <= exp_adv;
                if (cap != exp_adv[DW:0] && errcnt != 6'h3F)
                    errcnt <= errcnt + 6'd1;
            end
        end
    end

    assign LEDS = {errcnt, dena_s2, clok_s2};
`else
    assign LEDS = {state[5:0], dena_s2, clok_s2};
`endif

endmodule

// File: tb/tb_bus_exerciser.sv
// Testbench for bus_exerciser: directed scenarios plus randomized steps,
// all checked against a behavioural model of the state register.
module tb_bus_exerciser;
    localparam int          DW   = 12;
    localparam int          LW   = 32;
    localparam int          AW   = 4;
    localparam logic [31:0] SEED = 32'h87654321;
    localparam logic [31:0] TAPS = 32'h80200003;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic          reset_n, clock_n, dena_n;
    logic [1:0]    mode;
    logic          drv;
    logic [DW-1:0] drv_data;
    logic          drv_link;
    wire  [DW-1:0] data_bus;
    wire           link_bus;
    logic [AW-1:0] aux;
    logic [7:0]    leds;

    assign data_bus = drv ? drv_data : {DW{1'bz}};
    assign link_bus = drv ? drv_link : 1'bz;

    bus_exerciser #(.DW(DW), .LW(LW), .AW(AW), .SEED(SEED), .TAPS(TAPS)) dut (
        .FIFTYMHZ (clk),
        ._RESET   (reset_n),
        ._CLOCK   (clock_n),
        ._DENA    (dena_n),
        .MODE     (mode),
        .DATA     (data_bus),
        .LINK     (link_bus),
        .AUX      (aux),
        .LEDS     (leds)
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [31:0] m_state, m_exp;
    int          m_err;

    function automatic logic [31:0] m_lfsr(input logic [31:0] s);
        logic [31:0] n;
        n = (s << 1) | 32'($countones(s & TAPS) % 2);
        return (n == 32'd0) ? SEED : n;
    endfunction

    function automatic logic [7:0] exp_leds();
        logic [5:0] hi;
`ifdef BUS_EXERCISER_ERRCNT_EN
        hi = 6'(m_err);
`else
        hi = m_state[5:0];
`endif
        return {hi, dena_n, 1'b0};
    endfunction

    task automatic model_step();
        logic [31:0] ns, e;
        logic [12:0] c;
        if (dena_n) begin
            c  = {~drv_link, ~drv_data};
            ns = (m_state & ~32'h1FFF) | {19'd0, c};
            if (mode == 2'b11) begin
                m_exp = ns;
            end else begin
                e = m_lfsr(m_exp);
                if (e[12:0] != c && m_err < 63) m_err = m_err + 1;
                m_exp = e;
            end
            m_state = ns;
        end else begin
            case (mode)
                2'b00: m_state = m_lfsr(m_state);
                2'b01: m_state = m_state + 32'd1;
                2'b10: m_state = (m_state << 1) | (m_state >> 31);
                default: ;
            endcase
        end
    endtask

    task automatic pulse();
        @(negedge clk) clock_n = 1'b0;
        repeat (4) @(negedge clk);
        clock_n = 1'b1;
        repeat (4) @(negedge clk);
        model_step();
    endtask

    task automatic do_reset(input logic dn, input logic [1:0] md);
        @(negedge clk);
        reset_n = 1'b0;
        clock_n = 1'b1;
        dena_n  = dn;
        drv     = dn;
        mode    = md;
        m_state = SEED;
        m_exp   = SEED;
        m_err   = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0; clock_n = 1'b1; dena_n = 1'b0; mode = 2'b00; drv = 1'b0;
        m_state = SEED; m_exp = SEED; m_err = 0;
        repeat (3) @(negedge clk);
        checks++; if (data_bus !== 12'h321) begin errors++; $display("FAIL reset_data got %h want 321", data_bus); end
        checks++; if (link_bus !== 1'b0) begin errors++; $display("FAIL reset_link got %b want 0", link_bus); end
        checks++; if (aux !== SEED[16:13]) begin errors++; $display("FAIL reset_aux got %b want %b", aux, SEED[16:13]); end
        checks++; if (leds !== exp_leds()) begin errors++; $display("FAIL reset_leds got %h want %h", leds, exp_leds()); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_lfsr_first();
        do_reset(1'b0, 2'b00);
        pulse();
        checks++; if (data_bus !== 12'h643) begin errors++; $display("FAIL lfsr1_data got %h want 643", data_bus); end
        checks++; if (link_bus !== 1'b0) begin errors++; $display("FAIL lfsr1_link got %b want 0", link_bus); end
        checks++; if (aux !== 4'b0100) begin errors++; $display("FAIL lfsr1_aux got %b want 0100", aux); end
        checks++; if (m_state !== 32'h0ECA8643) begin errors++; $display("FAIL lfsr1_model got %h want 0eca8643", m_state); end
        checks++; if (leds !== exp_leds()) begin errors++; $display("FAIL lfsr1_leds got %h want %h", leds, exp_leds()); end
    endtask

    task automatic test_count_wrap();
        do_reset(1'b0, 2'b01);
        pulse();
        checks++; if (data_bus !== 12'h322 || link_bus !== 1'b0) begin errors++; $display("FAIL count1 got %b_%h want 0_322", link_bus, data_bus); end
        repeat (4096) pulse();
        checks++; if (data_bus !== 12'h322 || link_bus !== 1'b1) begin errors++; $display("FAIL count4097 got %b_%h want 1_322", link_bus, data_bus); end
        checks++; if (aux !== m_state[16:13]) begin errors++; $display("FAIL count_aux got %b want %b", aux, m_state[16:13]); end
    endtask

    task automatic test_capture();
        drv_data = 12'hABC; drv_link = 1'b1;
        do_reset(1'b1, 2'b00);
        pulse();
        checks++; if (data_bus !== 12'hABC || link_bus !== 1'b1) begin errors++; $display("FAIL cap_undriven got %b_%h want 1_abc", link_bus, data_bus); end
        checks++; if (aux !== 4'b1010) begin errors++; $display("FAIL cap_aux got %b want 1010", aux); end
        checks++; if (leds !== exp_leds()) begin errors++; $display("FAIL cap_leds got %h want %h", leds, exp_leds()); end
        @(negedge clk);
        drv = 1'b0; dena_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (data_bus !== 12'h543 || link_bus !== 1'b0) begin errors++; $display("FAIL cap_state got %b_%h want 0_543", link_bus, data_bus); end
        checks++; if (m_state !== 32'h87654543) begin errors++; $display("FAIL cap_model got %h want 87654543", m_state); end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0, 2'b00);
        @(negedge clk) clock_n = 1'b0;
        @(negedge clk) reset_n = 1'b0;
        m_state = SEED; m_exp = SEED; m_err = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (data_bus !== 12'h321 || aux !== SEED[16:13]) begin errors++; $display("FAIL rstmid_held got %h/%b want 321/%b", data_bus, aux, SEED[16:13]); end
        clock_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (data_bus !== 12'h321) begin errors++; $display("FAIL rstmid_rise got %h want 321", data_bus); end
        pulse();
        checks++; if (data_bus !== 12'h643) begin errors++; $display("FAIL rstmid_fresh got %h want 643", data_bus); end
    endtask

    task automatic test_random();
        int bad;
        do_reset(1'b0, 2'b00);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            dena_n   = ($urandom_range(0, 3) == 0);
            drv      = dena_n;
            mode     = 2'($urandom_range(0, 3));
            drv_data = 12'($urandom);
            drv_link = 1'($urandom);
            repeat (4) @(negedge clk);
            pulse();
            checks++;
            if (aux !== m_state[16:13] || leds !== exp_leds() ||
                (!dena_n && (data_bus !== m_state[11:0] || link_bus !== m_state[12]))) begin
                errors++;
                if (bad < 5)
                    $display("FAIL random step %0d got aux %b leds %h bus %b_%h want aux %b leds %h state %h",
                             i, aux, leds, link_bus, data_bus, m_state[16:13], exp_leds(), m_state);
                bad++;
            end
        end
        @(negedge clk);
        drv = 1'b0; dena_n = 1'b0;
    endtask

`ifdef BUS_EXERCISER_ERRCNT_EN
    task automatic test_errcnt_sat();
        drv_data = 12'($urandom); drv_link = 1'b0;
        do_reset(1'b1, 2'b11);
        pulse();
        @(negedge clk);
        mode = 2'b00; drv_data = 12'h000; drv_link = 1'b0;
        repeat (4) @(negedge clk);
        repeat (70) pulse();
        checks++; if (leds[7:2] !== 6'h3F || m_err != 63) begin errors++; $display("FAIL errsat got %h model %0d want 3f", leds[7:2], m_err); end
        repeat (5) pulse();
        checks++; if (leds[7:2] !== 6'h3F) begin errors++; $display("FAIL errsat_hold got %h want 3f", leds[7:2]); end
    endtask

    task automatic test_errcnt_clean();
        logic [31:0] e;
        do_reset(1'b1, 2'b00);
        for (int i = 0; i < 100; i++) begin
            e = m_lfsr(m_exp);
            @(negedge clk);
            drv_data = ~e[11:0]; drv_link = ~e[12];
            pulse();
        end
        checks++; if (leds[7:2] !== 6'h00 || m_err != 0) begin errors++; $display("FAIL errclean got %h model %0d want 00", leds[7:2], m_err); end
    endtask
`endif

    initial begin
        reset_n = 1'b0; clock_n = 1'b1; dena_n = 1'b0; mode = 2'b00;
        drv = 1'b0; drv_data = '0; drv_link = 1'b0;
        m_state = SEED; m_exp = SEED; m_err = 0;
        test_reset();
        test_lfsr_first();
        test_count_wrap();
        test_capture();
        test_reset_mid();
        test_random();
`ifdef BUS_EXERCISER_ERRCNT_EN
        test_errcnt_sat();
        test_errcnt_clean();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
